// File: rtl/nr_pkg.sv
// Shared types and constants for the NR frame controller: FSM states, dimension limits,
// border bit positions and a frame-dimension validity helper.
package nr_pkg;

   localparam int unsigned NR_DIM_W   = 13;
   localparam int unsigned NR_MIN_DIM = 3;

   typedef enum logic [1:0] {
      StIdle,
      StWaitSof,
      StActive,
      StDone
   } nr_fsm_e;

   // Bit positions within border_o, packed as {top,bottom,left,right}.
   typedef enum logic [1:0] {
      BrdRight  = 2'd0,
      BrdLeft   = 2'd1,
      BrdBottom = 2'd2,
      BrdTop    = 2'd3
   } nr_border_idx_e;

   function automatic logic dim_ok(input logic [NR_DIM_W-1:0] dim, input int unsigned max_dim);
      return (32'(dim) >= NR_MIN_DIM) && (32'(dim) <= max_dim);
   endfunction

endpackage

// File: rtl/nr_pos_counter.sv
// Pixel x/y position counter with end-of-line/end-of-frame wrap and frame-edge decode.
// x_o/y_o always name the next pixel to be accepted.
module nr_pos_counter
   import nr_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clr_i,
   input  logic                first_i,
   input  logic                adv_i,
   input  logic                en_i,
   input  logic [NR_DIM_W-1:0] width_i,
   input  logic [NR_DIM_W-1:0] height_i,
   output logic [NR_DIM_W-1:0] x_o,
   output logic [NR_DIM_W-1:0] y_o,
   output logic [3:0]          border_o,
   output logic                last_o
);

   logic [NR_DIM_W-1:0] x_q, x_d, y_q, y_d;
   logic                x_end, y_end;

   assign x_end  = (x_q == width_i - NR_DIM_W'(1));
   assign y_end  = (y_q == height_i - NR_DIM_W'(1));
   assign last_o = x_end & y_end;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (first_i) begin
         // The pixel arriving with sof_i is (0,0), so the next one is (1,0).
         x_d = NR_DIM_W'(1);
         y_d = '0;
      end else if (adv_i) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + NR_DIM_W'(1);
         end else begin
            x_d = x_q + NR_DIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   always_comb begin
      border_o = '0;
      if (en_i) begin
         border_o[BrdTop]    = (y_q == '0);
         border_o[BrdBottom] = y_end;
         border_o[BrdLeft]   = (x_q == '0);
         border_o[BrdRight]  = x_end;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;

endmodule

// File: rtl/nr_frame_ctrl.sv
// NR frame controller: frame FSM, shadowed config, reference ping-pong select.
// Define NR_FRAME_ERR_EN to get a sticky err_o for aborted frames and rejected sof_i.
module nr_frame_ctrl
   import nr_pkg::*;
#(
   parameter int unsigned IMG_MAX = 4096
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                cfg_enable_i,
   input  logic [7:0]          cfg_strength_i,
   input  logic [NR_DIM_W-1:0] cfg_width_i,
   input  logic [NR_DIM_W-1:0] cfg_height_i,
   input  logic                sof_i,
   input  logic                pix_valid_i,
   output logic [NR_DIM_W-1:0] x_o,
   output logic [NR_DIM_W-1:0] y_o,
   output logic [3:0]          border_o,
   output logic                act_enable_o,
   output logic [7:0]          act_strength_o,
   output logic                wr_buf_o,
   output logic                rd_buf_o,
   output logic                ref_valid_o,
   output logic                frame_done_o,
   output logic                busy_o,
   output logic                err_o
);

   nr_fsm_e             state_q;
   logic [NR_DIM_W-1:0] shd_w_q, shd_h_q;
   logic                shd_en_q;
   logic [7:0]          shd_str_q;
   logic                wr_buf_q, ref_valid_q, frame_done_q, busy_q;
   logic                cfg_ok, shd_load;
   logic                cnt_clr, cnt_first, cnt_adv, cnt_last;

   assign cfg_ok   = dim_ok(cfg_width_i, IMG_MAX) && dim_ok(cfg_height_i, IMG_MAX);
   assign shd_load = sof_i && cfg_ok &&
                     (((state_q == StWaitSof) && cfg_enable_i) || (state_q == StActive));

   always_comb begin
      cnt_clr   = 1'b0;
      cnt_first = 1'b0;
      cnt_adv   = 1'b0;
      unique case (state_q)
         StWaitSof: cnt_first = shd_load && pix_valid_i;
         StActive: begin
            cnt_clr = sof_i;
            cnt_adv = pix_valid_i && !sof_i;
         end
         default: ;
      endcase
   end

   nr_pos_counter u_pos (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (cnt_clr),
      .first_i  (cnt_first),
      .adv_i    (cnt_adv),
      .en_i     (state_q == StActive),
      .width_i  (shd_w_q),
      .height_i (shd_h_q),
      .x_o      (x_o),
      .y_o      (y_o),
      .border_o (border_o),
      .last_o   (cnt_last)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shd_w_q   <= '0;
         shd_h_q   <= '0;
         shd_en_q  <= 1'b0;
         shd_str_q <= '0;
      end else if (shd_load) begin
         shd_w_q   <= cfg_width_i;
         shd_h_q   <= cfg_height_i;
         shd_en_q  <= cfg_enable_i;
         shd_str_q <= cfg_strength_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= StIdle;
         wr_buf_q     <= 1'b0;
         ref_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ref_valid_q <= 1'b0;
               if (cfg_enable_i) state_q <= StWaitSof;
            end
            StWaitSof: begin
               if (!cfg_enable_i) begin
                  state_q     <= StIdle;
                  ref_valid_q <= 1'b0;
               end else if (shd_load) begin
                  state_q <= StActive;
                  busy_q  <= 1'b1;
               end
            end
            StActive: begin
               if (sof_i) begin
                  // Abort: a valid config restarts the frame in place, else re-arm.
                  ref_valid_q <= 1'b0;
                  if (!cfg_ok) begin
                     state_q <= StWaitSof;
                     busy_q  <= 1'b0;
                  end
               end else if (pix_valid_i && cnt_last) begin
                  state_q      <= StDone;
                  frame_done_q <= 1'b1;
                  wr_buf_q     <= ~wr_buf_q;
                  ref_valid_q  <= shd_en_q;
               end
            end
            StDone: begin
               busy_q <= 1'b0;
               if (cfg_enable_i) begin
                  state_q <= StWaitSof;
               end else begin
                  state_q     <= StIdle;
                  ref_valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef NR_FRAME_ERR_EN
   logic err_q, err_set;

   assign err_set = sof_i && ((state_q == StActive) ||
                              ((state_q == StWaitSof) && cfg_enable_i && !cfg_ok));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign act_enable_o   = shd_en_q;
   assign act_strength_o = shd_str_q;
   assign wr_buf_o       = wr_buf_q;
   assign rd_buf_o       = ~wr_buf_q;
   assign ref_valid_o    = ref_valid_q;
   assign frame_done_o   = frame_done_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_nr_frame_ctrl.sv
// Directed self-checking bench for nr_frame_ctrl; DUT built with a reduced IMG_MAX so the
// full-size frame runs in a few thousand cycles.
module tb_nr_frame_ctrl;

   localparam int unsigned ImgMax = 64;
`ifdef NR_FRAME_ERR_EN
   localparam logic ErrExp = 1'b1;
`else
   localparam logic ErrExp = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        cfg_enable_i;
   logic [7:0]  cfg_strength_i;
   logic [12:0] cfg_width_i, cfg_height_i;
   logic        sof_i, pix_valid_i;
   logic [12:0] x_o, y_o;
   logic [3:0]  border_o;
   logic        act_enable_o;
   logic [7:0]  act_strength_o;
   logic        wr_buf_o, rd_buf_o, ref_valid_o, frame_done_o, busy_o, err_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk_i = ~clk_i;

   nr_frame_ctrl #(.IMG_MAX(ImgMax)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .cfg_enable_i   (cfg_enable_i),
      .cfg_strength_i (cfg_strength_i),
      .cfg_width_i    (cfg_width_i),
      .cfg_height_i   (cfg_height_i),
      .sof_i          (sof_i),
      .pix_valid_i    (pix_valid_i),
      .x_o            (x_o),
      .y_o            (y_o),
      .border_o       (border_o),
      .act_enable_o   (act_enable_o),
      .act_strength_o (act_strength_o),
      .wr_buf_o       (wr_buf_o),
      .rd_buf_o       (rd_buf_o),
      .ref_valid_o    (ref_valid_o),
      .frame_done_o   (frame_done_o),
      .busy_o         (busy_o),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"}, 32'(x_o), 0);
      chk({tag, "_y"}, 32'(y_o), 0);
      chk({tag, "_border"}, 32'(border_o), 0);
      chk({tag, "_act_en"}, 32'(act_enable_o), 0);
      chk({tag, "_act_str"}, 32'(act_strength_o), 0);
      chk({tag, "_wr_buf"}, 32'(wr_buf_o), 0);
      chk({tag, "_rd_buf"}, 32'(rd_buf_o), 1);
      chk({tag, "_ref_valid"}, 32'(ref_valid_o), 0);
      chk({tag, "_frame_done"}, 32'(frame_done_o), 0);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_err"}, 32'(err_o), 0);
   endtask

   initial begin
      rst_n_i        = 1'b0;
      cfg_enable_i   = 1'b0;
      cfg_strength_i = 8'h00;
      cfg_width_i    = '0;
      cfg_height_i   = '0;
      sof_i          = 1'b0;
      pix_valid_i    = 1'b0;
      tick();
      tick();
      chk_reset("rst");

      // Frame 1: 4x3, strength 0x10, strength rewritten mid-frame.
      rst_n_i        = 1'b1;
      cfg_enable_i   = 1'b1;
      cfg_width_i    = 13'd4;
      cfg_height_i   = 13'd3;
      cfg_strength_i = 8'h10;
      tick();
      chk("s1_wait_busy", 32'(busy_o), 0);
      sof_i = 1'b1;
      tick();
      sof_i = 1'b0;
      chk("s1_busy", 32'(busy_o), 1);
      chk("s1_act_en", 32'(act_enable_o), 1);
      chk("s1_act_str", 32'(act_strength_o), 32'h10);
      for (int i = 0; i < 12; i++) begin
         pix_valid_i = 1'b1;
         chk("s1_x", 32'(x_o), i % 4);
         chk("s1_y", 32'(y_o), i / 4);
         chk("s1_border", 32'(border_o),
             {28'd0, (i / 4) == 0, (i / 4) == 2, (i % 4) == 0, (i % 4) == 3});
         chk("s1_done_low", 32'(frame_done_o), 0);
         if (i == 5) cfg_strength_i = 8'h40;
         if (i > 5) chk("s2_str_held", 32'(act_strength_o), 32'h10);
         tick();
      end
      pix_valid_i = 1'b0;
      chk("s1_done", 32'(frame_done_o), 1);
      chk("s1_wr_buf", 32'(wr_buf_o), 1);
      chk("s1_rd_buf", 32'(rd_buf_o), 0);
      chk("s1_ref_valid", 32'(ref_valid_o), 1);
      chk("s1_done_busy", 32'(busy_o), 1);
      tick();
      chk("s1_done_once", 32'(frame_done_o), 0);
      chk("s1_post_busy", 32'(busy_o), 0);
      chk("s2_str_wait", 32'(act_strength_o), 32'h10);
      sof_i = 1'b1;
      tick();
      sof_i = 1'b0;
      chk("s2_str_new", 32'(act_strength_o), 32'h40);

      // Abort after 5 of 12 pixels.
      for (int i = 0; i < 5; i++) begin
         pix_valid_i = 1'b1;
         tick();
      end
      pix_valid_i = 1'b0;
      chk("s3_x_pre", 32'(x_o), 1);
      chk("s3_y_pre", 32'(y_o), 1);
      sof_i = 1'b1;
      tick();
      sof_i = 1'b0;
      chk("s3_x", 32'(x_o), 0);
      chk("s3_y", 32'(y_o), 0);
      chk("s3_ref_valid", 32'(ref_valid_o), 0);
      chk("s3_wr_buf", 32'(wr_buf_o), 1);
      chk("s3_err", 32'(err_o), 32'(ErrExp));
      chk("s3_busy", 32'(busy_o), 1);

      // Width 2 is too narrow: the abort re-arms, then sof_i is rejected.
      cfg_width_i = 13'd2;
      sof_i = 1'b1;
      tick();
      chk("s4_abort_busy", 32'(busy_o), 0);
      tick();
      sof_i = 1'b0;
      chk("s4_busy", 32'(busy_o), 0);
      chk("s4_err", 32'(err_o), 32'(ErrExp));
      pix_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      pix_valid_i = 1'b0;
      chk("s4_x", 32'(x_o), 0);
      chk("s4_y", 32'(y_o), 0);
      chk("s4_border", 32'(border_o), 0);
      chk("s4_busy_ign", 32'(busy_o), 0);
      chk("s4_done", 32'(frame_done_o), 0);

      // Reset pulse at pixel 7 of a 4x3 frame.
      cfg_width_i = 13'd4;
      sof_i = 1'b1;
      tick();
      sof_i = 1'b0;
      pix_valid_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("s5_x7", 32'(x_o), 3);
      chk("s5_y7", 32'(y_o), 1);
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      pix_valid_i = 1'b0;
      chk_reset("s5");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("s5_no_done", 32'(frame_done_o), 0);
      end

      // Upper bound: width one past IMG_MAX rejected, then a full IMG_MAX x IMG_MAX frame.
      cfg_width_i  = 13'(ImgMax + 1);
      cfg_height_i = 13'(ImgMax);
      sof_i = 1'b1;
      tick();
      sof_i = 1'b0;
      chk("s6_reject_busy", 32'(busy_o), 0);
      chk("s6_reject_err", 32'(err_o), 32'(ErrExp));
      cfg_width_i = 13'(ImgMax);
      sof_i = 1'b1;
      pix_valid_i = 1'b1;
      chk("s6_x0", 32'(x_o), 0);
      chk("s6_y0", 32'(y_o), 0);
      tick();
      sof_i = 1'b0;
      chk("s6_busy", 32'(busy_o), 1);
      for (int i = 1; i < int'(ImgMax * ImgMax); i++) begin
         chk("s6_x", 32'(x_o), 32'(i) % ImgMax);
         chk("s6_y", 32'(y_o), 32'(i) / ImgMax);
         tick();
      end
      pix_valid_i = 1'b0;
      chk("s6_done", 32'(frame_done_o), 1);
      chk("s6_x_wrap", 32'(x_o), 0);
      chk("s6_y_wrap", 32'(y_o), 0);
      chk("s6_wr_buf", 32'(wr_buf_o), 1);
      tick();
      chk("s6_done_once", 32'(frame_done_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nr_frame_ctrl.md
NR_FRAME_CTRL -- requirements
Module: nr_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_MAX, default 4096, meaning the maximum frame width and height in pixels.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have inputs cfg_enable_i (1), cfg_strength_i (8), cfg_width_i (13), cfg_height_i (13): the live NR configuration.
REQ-005 SHALL have inputs sof_i (1, start-of-frame strobe) and pix_valid_i (1, pixel accepted this cycle).
REQ-006 SHALL have outputs x_o (13) and y_o (13): the coordinate of the current pixel.
REQ-007 SHALL have output border_o (4), bits {top,bottom,left,right}, asserted when the current pixel is on that frame edge.
REQ-008 SHALL have outputs act_enable_o (1) and act_strength_o (8): the shadowed configuration applied to the datapath.
REQ-009 SHALL have outputs wr_buf_o (1) and rd_buf_o (1): reference-frame ping-pong selects, with rd_buf_o always equal to ~wr_buf_o.
REQ-010 SHALL have outputs ref_valid_o (1), frame_done_o (1), busy_o (1) and err_o (1).

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_SOF, ACTIVE and DONE.
REQ-012 IDLE->WAIT_SOF when cfg_enable_i=1; WAIT_SOF->IDLE when cfg_enable_i=0.
REQ-013 WAIT_SOF->ACTIVE on sof_i, but only when 3<=cfg_width_i<=IMG_MAX and 3<=cfg_height_i<=IMG_MAX; otherwise remain in WAIT_SOF.
REQ-014 On entry to ACTIVE, SHALL latch width, height, enable and strength into shadow registers; act_* outputs reflect only the shadow values.
REQ-015 Config changes during ACTIVE SHALL have no effect until the next accepted sof_i.
REQ-016 In ACTIVE, x_o/y_o/border_o SHALL describe the pixel presented with pix_valid_i in the same cycle, driven from registered counters.
REQ-017 Each pix_valid_i: x increments; at x=W-1, x wraps to 0 and y increments.
REQ-018 The pixel at (W-1,H-1) SHALL cause ACTIVE->DONE.
REQ-019 sof_i and pix_valid_i in the same WAIT_SOF cycle SHALL count that pixel as (0,0); the counters then advance to (1,0).
REQ-020 pix_valid_i outside ACTIVE SHALL be ignored.
REQ-021 In DONE (exactly one cycle): frame_done_o=1 and wr_buf_o toggles.
REQ-022 In DONE, ref_valid_o SHALL be set if the shadow enable is 1, or cleared if it is 0.
REQ-023 DONE SHALL go to WAIT_SOF if cfg_enable_i=1, else to IDLE.
REQ-024 sof_i during ACTIVE SHALL abort the frame: counters return to (0,0), ref_valid_o clears, wr_buf_o is unchanged, and the shadow config is re-latched (same validity rule as REQ-013, else go to WAIT_SOF).
REQ-025 In IDLE, ref_valid_o SHALL clear.
REQ-026 busy_o SHALL be 1 exactly in ACTIVE and DONE.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs, except that x_o/y_o/border_o follow REQ-016.

Reset
REQ-028 When rst_n_i=0 at a clock edge, the state SHALL go to IDLE and all of x_o, y_o, border_o, act_enable_o, act_strength_o, wr_buf_o, ref_valid_o, frame_done_o, busy_o and err_o SHALL be 0; rd_buf_o SHALL be 1.
REQ-029 Reset mid-frame SHALL discard the frame with no frame_done_o pulse.

Configuration
REQ-030 Macro NR_FRAME_ERR_EN defined: err_o SHALL be a sticky flag set by an ACTIVE abort (REQ-024) or by a rejected sof_i (REQ-013), and cleared only by reset.
REQ-031 Macro NR_FRAME_ERR_EN undefined: err_o SHALL be tied to 0 with no error logic present; all other behaviour is unchanged.

Structure
REQ-032 Package nr_pkg SHALL hold the state enum nr_fsm_e, the constant NR_DIM_W=13, the constant NR_MIN_DIM=3, and a border-bit index typedef.
REQ-033 The x/y counter with wrap and border decode SHALL be a sub-module named nr_pos_counter; the FSM, shadowing and ping-pong logic stay in nr_frame_ctrl.

Verification
REQ-034 Scenario 1: enable=1, W=4, H=3, sof_i then 12 pix_valid_i -> coordinates (0,0)..(3,2); border_o=1010 at (0,0); frame_done_o pulses once, the cycle after the 12th pixel; wr_buf_o 0->1; ref_valid_o=1.
REQ-035 Scenario 2: strength changed 0x10->0x40 mid-frame -> act_strength_o stays 0x10 until the next sof_i, then becomes 0x40.
REQ-036 Scenario 3: sof_i after 5 of 12 pixels -> x_o/y_o return to (0,0), ref_valid_o=0, wr_buf_o unchanged, and err_o=1 if NR_FRAME_ERR_EN is defined, else 0.
REQ-037 Scenario 4: W=2 with sof_i -> state stays WAIT_SOF, busy_o=0, err_o=1 (with NR_FRAME_ERR_EN); the following pix_valid_i are ignored.
REQ-038 Scenario 5: rst_n_i=0 for 1 cycle at pixel 7 -> all outputs at reset values on the next edge, rd_buf_o=1, no frame_done_o pulse.
REQ-039 Scenario 6: sof_i together with the first pix_valid_i, W=H=IMG_MAX -> the first pixel is (0,0); after 16777216 pixels frame_done_o pulses and x/y wrap to 0 with no overflow.
